idli_ctl_m: RTL and testbench
=============================

Name: idli_ctl_m

Overview:
Core sync/control block. Owns the free-running 2-bit slice counter (ctr_t) and schedules the single shared SQI memory path between three requesters: sequential instruction fetch, branch redirects, and data load/store from execute. It drives redirect, write-enable and address to idli_sqi_m, gates decode-valid, and tracks the architectural fetch PC. All scheduling decisions are made on word boundaries, i.e. cycles where ctr == 3.

Parameters:
P_RESET_PC, 16'h0000, fetch address issued by the first redirect after reset.
P_OVHD_WORDS, 2, number of 4-cycle words of SQI command/address overhead after a redirect before the first data word. Legal range is 1..7.

Ports:
i_ctl_gck  in  1  core clock.
i_ctl_rst  in  1  synchronous active-high reset.
o_ctl_ctr  out  2  slice counter, broadcast to sqi/decode.
i_ctl_br_vld  in  1  branch-taken pulse from execute; may arrive on any cycle.
i_ctl_br_addr  in  16  branch target (word address), valid with br_vld.
i_ctl_ld_req  in  1  load request; level, held until granted.
i_ctl_st_req  in  1  store request; level, held until granted. Must not be asserted together with ld_req.
i_ctl_mem_addr  in  16  load/store word address, stable while a request is held.
o_ctl_mem_gnt  out  1  one-cycle pulse: request accepted.
o_ctl_mem_done  out  1  one-cycle pulse: data word transferred.
o_ctl_sqi_redirect  out  1  starts a new SQI transaction.
o_ctl_sqi_wr_en  out  1  SQI data word is a write.
o_ctl_sqi_addr  out  16  address for the transaction; valid with redirect.
i_ctl_sqi_vld  in  1  SQI word complete (pulses at ctr == 3).
o_ctl_de_vld  out  1  word is a valid instruction for decode.
o_ctl_pc  out  16  address of the next instruction word expected.

Behaviour:
Clock/reset: one clock i_ctl_gck. Reset i_ctl_rst is synchronous and active-high.

Reset values:
- ctr = 0, state = BOOT.
- redirect, wr_en, gnt, done, de_vld = 0.
- sqi_addr = pc = P_RESET_PC.
- Pending-branch flag = 0, wait counter = 0.
- Asserting reset mid-transaction aborts it immediately. No done pulse is produced and any pending request is dropped.

Counter: ctr increments by 1 every cycle out of reset and wraps 3 -> 0. Word boundary W means ctr == 3.

Branch capture: br_vld sets the pending flag and latches br_addr. A later br_vld before the branch is serviced overwrites the latched address. A br_vld arriving on the same cycle the pending branch is serviced re-arms the flag with the new target.

States:
- BOOT: at the first W, assert redirect with addr = pc and go to OVHD_F.
- OVHD_F: wait counter loaded with P_OVHD_WORDS on the redirect cycle and decremented at each W. When it reaches 0 at a W, go to FETCH. sqi_vld is ignored in this state.
- FETCH: on each W, the highest-priority rule applies:
  1. Pending branch: redirect with addr = target, pc <= target, clear the flag, go to OVHD_F. A sqi_vld on this same cycle is squashed (de_vld = 0).
  2. ld_req or st_req: gnt = 1, redirect with addr = mem_addr, wr_en latched from st_req, go to OVHD_D. A sqi_vld on this cycle still produces de_vld = 1 and pc += 1.
  3. Otherwise, if sqi_vld: de_vld = 1, pc += 1 (mod 2^16).
- OVHD_D: same wait mechanism as OVHD_F, then go to DATA.
- DATA: one word. For a store, wr_en is high for all 4 cycles of the data word. At its W, done = 1. Then redirect to the target if a branch is pending (pc <= target, clear the flag), otherwise redirect to pc. Go to OVHD_F.

Other timing rules:
- Redirect is only ever high at W.
- A branch pending in OVHD_F is serviced at the next FETCH W, not earlier. A branch pending in OVHD_D/DATA waits until the DATA exit.
- Simultaneous branch and memory request: the branch wins; the request stays held and is granted at a later W.
- de_vld is never asserted outside FETCH.
- pc wraps 16'hFFFF -> 16'h0000.

Decomposition:
- idli_pkg adds ctl_state_t (BOOT, OVHD_F, FETCH, OVHD_D, DATA) and CTL_WAIT_W = 3. ctr_t, data_t and slice_t are reused.
- One natural sub-module: idli_ctl_wait_m, a loadable word-down-counter that decrements on W and flags zero.

Test Plan:
- Reset release, P_OVHD_WORDS = 2 -> redirect at cycle 3 with addr 0. The first sqi_vld accepted is at cycle 15, giving de_vld = 1 and pc = 1.
- Continuous fetch, 5 sqi_vld pulses -> 5 de_vld pulses and pc = 5. Force pc = 16'hFFFF, then one more word -> pc = 0.
- br_vld to 16'h0040 at ctr = 1 -> redirect at the next W with addr 0x0040. sqi_vld on that W is squashed. The next de_vld follows after 2 overhead words.
- st_req to 16'h1234 together with br_vld to 0x0080 -> the branch is serviced first. gnt follows at the first FETCH W after the branch overhead. wr_en is high for 4 cycles, then done, then redirect to pc.
- ld_req granted, then br_vld during OVHD_D -> done pulse, then redirect to the branch target rather than the old pc.
- Assert reset during the DATA state of a store -> no done pulse and wr_en = 0 on the next cycle. Boot redirect to P_RESET_PC at ctr = 3 after release.

Source files
------------

// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core.
// The control block's FSM encoding and wait-counter width live here.
package idli_pkg;

   typedef logic [1:0]  ctr_t;
   typedef logic [3:0]  slice_t;
   typedef logic [15:0] data_t;

   typedef logic [2:0]  ctl_state_t;

   localparam ctl_state_t CTL_BOOT   = 3'd0;
   localparam ctl_state_t CTL_OVHD_F = 3'd1;
   localparam ctl_state_t CTL_FETCH  = 3'd2;
   localparam ctl_state_t CTL_OVHD_D = 3'd3;
   localparam ctl_state_t CTL_DATA   = 3'd4;

   localparam int CTL_WAIT_W = 3;
   localparam ctr_t CTR_WORD = 2'd3;

   // Word boundary: the last slice of a 4-cycle SQI word.
   function automatic logic is_word_end(input ctr_t ctr);
      return ctr == CTR_WORD;
   endfunction

endpackage

// File: rtl/idli_ctl_if.sv
// Control <-> execute/SQI/decode signal bundle for idli_ctl_m.
// Names keep the control block's own port names; slave is the control side.
interface idli_ctl_if;
   import idli_pkg::*;

   ctr_t  o_ctl_ctr;
   logic  i_ctl_br_vld;
   data_t i_ctl_br_addr;
   logic  i_ctl_ld_req;
   logic  i_ctl_st_req;
   data_t i_ctl_mem_addr;
   logic  o_ctl_mem_gnt;
   logic  o_ctl_mem_done;
   logic  o_ctl_sqi_redirect;
   logic  o_ctl_sqi_wr_en;
   data_t o_ctl_sqi_addr;
   logic  i_ctl_sqi_vld;
   logic  o_ctl_de_vld;
   data_t o_ctl_pc;

   modport slave (
      output o_ctl_ctr, o_ctl_mem_gnt, o_ctl_mem_done, o_ctl_sqi_redirect,
             o_ctl_sqi_wr_en, o_ctl_sqi_addr, o_ctl_de_vld, o_ctl_pc,
      input  i_ctl_br_vld, i_ctl_br_addr, i_ctl_ld_req, i_ctl_st_req,
             i_ctl_mem_addr, i_ctl_sqi_vld
   );

   modport master (
      input  o_ctl_ctr, o_ctl_mem_gnt, o_ctl_mem_done, o_ctl_sqi_redirect,
             o_ctl_sqi_wr_en, o_ctl_sqi_addr, o_ctl_de_vld, o_ctl_pc,
      output i_ctl_br_vld, i_ctl_br_addr, i_ctl_ld_req, i_ctl_st_req,
             i_ctl_mem_addr, i_ctl_sqi_vld
   );

endinterface

// File: rtl/idli_ctl_wait_m.sv
// Loadable word down-counter: counts SQI overhead words after a redirect.
// o_wait_zero fires on the word boundary where the count reaches zero.
module idli_ctl_wait_m
   import idli_pkg::*;
#(
   parameter int P_LOAD = 2
) (
   input  logic i_wait_gck,
   input  logic i_wait_rst,
   input  ctr_t i_wait_ctr,
   input  logic i_wait_load,
   output logic o_wait_zero
);

   typedef logic [CTL_WAIT_W-1:0] wait_t;

   localparam wait_t LOAD_VAL = wait_t'(P_LOAD);
   localparam wait_t ONE      = wait_t'(1);

   wait_t cnt_q, cnt_d;

   always_comb begin
      // NOTE: default every always_comb output first so no path infers a latch.
      cnt_d = cnt_q;
      if (i_wait_load) begin
         cnt_d = LOAD_VAL;
      end else if (is_word_end(i_wait_ctr) && (cnt_q != '0)) begin
         cnt_d = cnt_q - ONE;
      end
   end

   always_ff @(posedge i_wait_gck) begin
      // NOTE: state updates use <= so every flop samples pre-edge values.
      if (i_wait_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_wait_zero = is_word_end(i_wait_ctr) && (cnt_q == ONE);

endmodule

// File: rtl/idli_ctl_m.sv
// Core sync/control: slice counter, fetch PC and the scheduler that shares
// the single SQI path between fetch, branch redirects and load/store.
module idli_ctl_m
   import idli_pkg::*;
#(
   parameter data_t P_RESET_PC   = 16'h0000,
   parameter int    P_OVHD_WORDS = 2
) (
   input  logic           i_ctl_gck,
   input  logic           i_ctl_rst,
   idli_ctl_if.slave      ctl
);

   ctr_t       ctr_q, ctr_d;
   ctl_state_t state_q, state_d;
   data_t      pc_q, pc_d;
   data_t      sqi_addr_q, sqi_addr_d;
   data_t      br_addr_q, br_addr_d;
   logic       br_pend_q, br_pend_d;
   logic       wr_q, wr_d;

   logic       word_end;
   logic       wait_zero;
   logic       redirect;
   data_t      redir_addr;
   logic       gnt;
   logic       done;
   logic       de_vld;
   logic       br_take;

   assign word_end = is_word_end(ctr_q);

   idli_ctl_wait_m #(
      .P_LOAD (P_OVHD_WORDS)
   ) u_wait (
      .i_wait_gck  (i_ctl_gck),
      .i_wait_rst  (i_ctl_rst),
      .i_wait_ctr  (ctr_q),
      .i_wait_load (redirect),
      .o_wait_zero (wait_zero)
   );

   always_comb begin
      ctr_d      = ctr_q + 2'd1;
      state_d    = state_q;
      pc_d       = pc_q;
      br_addr_d  = br_addr_q;
      br_pend_d  = br_pend_q;
      wr_d       = wr_q;
      redirect   = 1'b0;
      redir_addr = pc_q;
      gnt        = 1'b0;
      done       = 1'b0;
      de_vld     = 1'b0;
      br_take    = 1'b0;

      case (state_q)
         CTL_BOOT: begin
            if (word_end) begin
               redirect = 1'b1;
               state_d  = CTL_OVHD_F;
            end
         end
         CTL_OVHD_F: begin
            if (wait_zero) state_d = CTL_FETCH;
         end
         CTL_FETCH: begin
            if (word_end) begin
               if (br_pend_q) begin
                  // The in-flight word belongs to the old stream: squash it.
                  redirect   = 1'b1;
                  redir_addr = br_addr_q;
                  pc_d       = br_addr_q;
                  br_take    = 1'b1;
                  state_d    = CTL_OVHD_F;
               end else begin
                  if (ctl.i_ctl_sqi_vld) begin
                     de_vld = 1'b1;
                     pc_d   = pc_q + 16'd1;
                  end
                  if (ctl.i_ctl_ld_req || ctl.i_ctl_st_req) begin
                     gnt        = 1'b1;
                     redirect   = 1'b1;
                     redir_addr = ctl.i_ctl_mem_addr;
                     wr_d       = ctl.i_ctl_st_req;
                     state_d    = CTL_OVHD_D;
                  end
               end
            end
         end
         CTL_OVHD_D: begin
            if (wait_zero) state_d = CTL_DATA;
         end
         CTL_DATA: begin
            if (word_end) begin
               done     = 1'b1;
               redirect = 1'b1;
               state_d  = CTL_OVHD_F;
               if (br_pend_q) begin
                  redir_addr = br_addr_q;
                  pc_d       = br_addr_q;
                  br_take    = 1'b1;
               end
            end
         end
         default: state_d = CTL_BOOT;
      endcase

      // A new branch on the servicing cycle re-arms with the newer target.
      if (br_take) br_pend_d = 1'b0;
      if (ctl.i_ctl_br_vld) begin
         br_pend_d = 1'b1;
         br_addr_d = ctl.i_ctl_br_addr;
      end

      sqi_addr_d = redirect ? redir_addr : sqi_addr_q;
   end

   always_ff @(posedge i_ctl_gck) begin
      if (i_ctl_rst) begin
         ctr_q      <= '0;
         state_q    <= CTL_BOOT;
         pc_q       <= P_RESET_PC;
         sqi_addr_q <= P_RESET_PC;
         br_addr_q  <= '0;
         br_pend_q  <= 1'b0;
         wr_q       <= 1'b0;
      end else begin
         ctr_q      <= ctr_d;
         state_q    <= state_d;
         pc_q       <= pc_d;
         sqi_addr_q <= sqi_addr_d;
         br_addr_q  <= br_addr_d;
         br_pend_q  <= br_pend_d;
         wr_q       <= wr_d;
      end
   end

   assign ctl.o_ctl_ctr          = ctr_q;
   assign ctl.o_ctl_mem_gnt      = gnt;
   assign ctl.o_ctl_mem_done     = done;
   assign ctl.o_ctl_sqi_redirect = redirect;
   assign ctl.o_ctl_sqi_wr_en    = (state_q == CTL_DATA) && wr_q;
   assign ctl.o_ctl_sqi_addr     = redirect ? redir_addr : sqi_addr_q;
   assign ctl.o_ctl_de_vld       = de_vld;
   assign ctl.o_ctl_pc           = pc_q;

endmodule

// File: tb/tb_idli_ctl_m.sv
// Self-checking bench for idli_ctl_m: expected output events are queued with
// their cycle when stimulus is driven, and a negedge monitor pops and compares.
module tb_idli_ctl_m;
   import idli_pkg::*;

   typedef enum logic [1:0] {EV_GNT, EV_DONE, EV_DEVLD, EV_REDIR} ev_kind_t;

   typedef struct {
      ev_kind_t    kind;
      logic [15:0] val;
      int          cyc;
   } ev_t;

   logic gck;
   logic rst;
   logic sqi_on;
   int   cyc;
   int   n_checks;
   int   n_errors;
   ev_t  sb[$];

   idli_ctl_if ctl_if ();

   idli_ctl_m #(
      .P_RESET_PC   (16'h0000),
      .P_OVHD_WORDS (2)
   ) dut (
      .i_ctl_gck (gck),
      .i_ctl_rst (rst),
      .ctl       (ctl_if.slave)
   );

   initial gck = 1'b0;
   always #5 gck = ~gck;

   // Cycle index: 0 is the first cycle out of reset (ctr == 0).
   always @(posedge gck) cyc <= rst ? 0 : cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push(input ev_kind_t kind, input logic [15:0] val, input int at);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      e.cyc  = at;
      sb.push_back(e);
   endtask

   task automatic observe(input ev_kind_t kind, input logic [15:0] val);
      ev_t e;
      check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("ev_kind", 32'(kind), 32'(e.kind));
         check("ev_val", 32'(val), 32'(e.val));
         check("ev_cyc", cyc, e.cyc);
      end
   endtask

   always @(negedge gck) begin
      if (!rst) begin
         if (ctl_if.o_ctl_mem_gnt)  observe(EV_GNT, ctl_if.o_ctl_sqi_addr);
         if (ctl_if.o_ctl_mem_done) observe(EV_DONE, 16'(ctl_if.o_ctl_sqi_wr_en));
         if (ctl_if.o_ctl_de_vld)   observe(EV_DEVLD, ctl_if.o_ctl_pc);
         if (ctl_if.o_ctl_sqi_redirect) begin
            check("redir_at_w", 32'(ctl_if.o_ctl_ctr), 32'd3);
            observe(EV_REDIR, ctl_if.o_ctl_sqi_addr);
         end
      end
   end

   task automatic step();
      @(posedge gck);
      #1;
      ctl_if.i_ctl_sqi_vld = sqi_on && (ctl_if.o_ctl_ctr == 2'd3);
   endtask

   task automatic goto_cyc(input int n);
      while (cyc < n) step();
   endtask

   task automatic branch(input logic [15:0] addr);
      ctl_if.i_ctl_br_vld  = 1'b1;
      ctl_if.i_ctl_br_addr = addr;
      step();
      ctl_if.i_ctl_br_vld  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      sqi_on   = 1'b1;
      rst      = 1'b1;
      ctl_if.i_ctl_br_vld   = 1'b0;
      ctl_if.i_ctl_br_addr  = '0;
      ctl_if.i_ctl_ld_req   = 1'b0;
      ctl_if.i_ctl_st_req   = 1'b0;
      ctl_if.i_ctl_mem_addr = '0;
      ctl_if.i_ctl_sqi_vld  = 1'b0;
      repeat (3) step();

      check("rst_ctr",      32'(ctl_if.o_ctl_ctr),          32'd0);
      check("rst_redirect", 32'(ctl_if.o_ctl_sqi_redirect), 32'd0);
      check("rst_wr_en",    32'(ctl_if.o_ctl_sqi_wr_en),    32'd0);
      check("rst_gnt",      32'(ctl_if.o_ctl_mem_gnt),      32'd0);
      check("rst_done",     32'(ctl_if.o_ctl_mem_done),     32'd0);
      check("rst_de_vld",   32'(ctl_if.o_ctl_de_vld),       32'd0);
      check("rst_pc",       32'(ctl_if.o_ctl_pc),           32'h0000);
      check("rst_sqi_addr", 32'(ctl_if.o_ctl_sqi_addr),     32'h0000);

      // Boot, two overhead words, then five fetched words.
      push(EV_REDIR, 16'h0000, 3);
      for (int i = 0; i < 5; i++) push(EV_DEVLD, 16'(i), 15 + 4 * i);
      rst = 1'b0;
      goto_cyc(32);
      check("pc_after_5", 32'(ctl_if.o_ctl_pc), 32'h0005);

      // Branch mid-word: serviced at next W, in-flight word squashed.
      goto_cyc(33);
      push(EV_REDIR, 16'h0040, 35);
      push(EV_DEVLD, 16'h0040, 47);
      branch(16'h0040);
      goto_cyc(48);
      check("pc_after_br", 32'(ctl_if.o_ctl_pc), 32'h0041);

      // PC wrap from 16'hFFFF.
      goto_cyc(49);
      push(EV_REDIR, 16'hFFFF, 51);
      push(EV_DEVLD, 16'hFFFF, 63);
      branch(16'hFFFF);
      goto_cyc(64);
      check("pc_wrap", 32'(ctl_if.o_ctl_pc), 32'h0000);

      // Store together with a branch: branch first, store granted later.
      goto_cyc(65);
      push(EV_REDIR, 16'h0080, 67);
      push(EV_GNT,   16'h1234, 79);
      push(EV_DEVLD, 16'h0080, 79);
      push(EV_REDIR, 16'h1234, 79);
      push(EV_DONE,  16'h0001, 91);
      push(EV_REDIR, 16'h0081, 91);
      push(EV_DEVLD, 16'h0081, 103);
      ctl_if.i_ctl_st_req   = 1'b1;
      ctl_if.i_ctl_mem_addr = 16'h1234;
      branch(16'h0080);
      goto_cyc(80);
      ctl_if.i_ctl_st_req = 1'b0;
      check("pc_after_gnt", 32'(ctl_if.o_ctl_pc), 32'h0081);
      goto_cyc(87);
      for (int c = 87; c <= 92; c++) begin
         check($sformatf("st_wr_en_c%0d", c), 32'(ctl_if.o_ctl_sqi_wr_en),
               32'((c >= 88) && (c <= 91)));
         step();
      end

      // Load, then a branch during OVHD_D: DATA exit goes to the target.
      goto_cyc(104);
      push(EV_GNT,   16'h0200, 107);
      push(EV_DEVLD, 16'h0082, 107);
      push(EV_REDIR, 16'h0200, 107);
      push(EV_DONE,  16'h0000, 119);
      push(EV_REDIR, 16'h0300, 119);
      push(EV_DEVLD, 16'h0300, 131);
      ctl_if.i_ctl_ld_req   = 1'b1;
      ctl_if.i_ctl_mem_addr = 16'h0200;
      goto_cyc(108);
      ctl_if.i_ctl_ld_req = 1'b0;
      goto_cyc(109);
      branch(16'h0300);
      goto_cyc(117);
      check("ld_wr_en", 32'(ctl_if.o_ctl_sqi_wr_en), 32'd0);
      goto_cyc(120);
      check("pc_ld_br", 32'(ctl_if.o_ctl_pc), 32'h0300);

      // Reset in the DATA word of a store: aborted, no done pulse.
      goto_cyc(132);
      push(EV_GNT,   16'h5555, 135);
      push(EV_DEVLD, 16'h0301, 135);
      push(EV_REDIR, 16'h5555, 135);
      ctl_if.i_ctl_st_req   = 1'b1;
      ctl_if.i_ctl_mem_addr = 16'h5555;
      goto_cyc(136);
      ctl_if.i_ctl_st_req = 1'b0;
      goto_cyc(145);
      check("st2_wr_en", 32'(ctl_if.o_ctl_sqi_wr_en), 32'd1);
      check("sb_empty_pre_rst", 32'(sb.size()), 32'd0);
      rst = 1'b1;
      step();
      check("abort_wr_en", 32'(ctl_if.o_ctl_sqi_wr_en), 32'd0);
      check("abort_done",  32'(ctl_if.o_ctl_mem_done),  32'd0);
      check("abort_ctr",   32'(ctl_if.o_ctl_ctr),       32'd0);
      check("abort_pc",    32'(ctl_if.o_ctl_pc),        32'h0000);
      step();
      push(EV_REDIR, 16'h0000, 3);
      push(EV_DEVLD, 16'h0000, 15);
      rst = 1'b0;
      goto_cyc(16);
      check("pc_reboot", 32'(ctl_if.o_ctl_pc), 32'h0001);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
